// File: rtl/wdg_seq_pkg.sv
// Shared constants, enums and step helpers for the watchdog sequencing master.
package wdg_seq_pkg;

  localparam logic [11:0] WDG_LOAD   = 12'h000;
  localparam logic [11:0] WDG_CTRL   = 12'h008;
  localparam logic [11:0] WDG_INTCLR = 12'h00C;
  localparam logic [11:0] WDG_LOCK   = 12'hC00;

  localparam logic [31:0] WDG_UNLOCK_KEY = 32'h1ACCE551;
  localparam logic [31:0] WDG_RELOCK     = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_NEXT,
    ST_DONE
  } wdg_state_e;

  typedef enum logic [1:0] {
    SEQ_CFG,
    SEQ_FEED,
    SEQ_DIS
  } wdg_seq_e;

  typedef enum logic [2:0] {
    STP_UNLOCK,
    STP_LOAD,
    STP_CTRL,
    STP_INTCLR,
    STP_LOCK
  } wdg_step_e;

  // Every sequence ends in LOCK, so anything past the middle step falls through to it.
  function automatic wdg_step_e step_next(input wdg_seq_e seq, input wdg_step_e step);
    wdg_step_e nxt;
    nxt = STP_LOCK;
    case (step)
      STP_UNLOCK: begin
        case (seq)
          SEQ_CFG:  nxt = STP_LOAD;
          SEQ_FEED: nxt = STP_INTCLR;
          default:  nxt = STP_CTRL;
        endcase
      end
      STP_LOAD: nxt = STP_CTRL;
      default:  nxt = STP_LOCK;
    endcase
    return nxt;
  endfunction

  function automatic logic [11:0] step_addr(input wdg_step_e step);
    logic [11:0] a;
    case (step)
      STP_LOAD:   a = WDG_LOAD;
      STP_CTRL:   a = WDG_CTRL;
      STP_INTCLR: a = WDG_INTCLR;
      default:    a = WDG_LOCK;
    endcase
    return a;
  endfunction

  function automatic logic [31:0] step_data(input wdg_step_e step, input logic [31:0] load,
                                            input logic [1:0] ctrl);
    logic [31:0] d;
    case (step)
      STP_UNLOCK: d = WDG_UNLOCK_KEY;
      STP_LOAD:   d = load;
      STP_CTRL:   d = {30'b0, ctrl};
      STP_INTCLR: d = 32'h0000_0001;
      default:    d = WDG_RELOCK;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/apbif.sv
// APB3 signal bundle between the sequencing master and the watchdog slave port.
interface apbif #(
  parameter int AW = 12
) ();
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;

  modport master (output paddr, psel, penable, pwrite, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  paddr, psel, penable, pwrite, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/wdg_seq_apbwr.sv
// Single APB write engine: start launches SETUP on the next edge, ACCESS holds until pready.
module wdg_seq_apbwr #(
  parameter int PAW = 12
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [PAW-1:0] addr,
  input  logic [31:0]    data,
  input  logic           pready,
  input  logic           pslverr,
  output logic           psel,
  output logic           penable,
  output logic           pwrite,
  output logic [PAW-1:0] paddr,
  output logic [31:0]    pwdata,
  output logic           wr_done,
  output logic           slverr
);

  logic           psel_q, psel_d;
  logic           penable_q, penable_d;
  logic [PAW-1:0] paddr_q, paddr_d;
  logic [31:0]    pwdata_q, pwdata_d;

  always_comb begin
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    wr_done   = psel_q & penable_q & pready;
    slverr    = psel_q & penable_q & pready & pslverr;
    if (!psel_q) begin
      if (start) begin
        psel_d   = 1'b1;
        paddr_d  = addr;
        pwdata_d = data;
      end
    end else if (!penable_q) begin
      penable_d = 1'b1;
    end else if (pready) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  // Only writes are ever issued, so pwrite simply follows psel.
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = psel_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule

// File: rtl/wdg_seq_ctrl.sv
// Watchdog sequencing master: request arbiter, step sequencer and auto-feed timer.
module wdg_seq_ctrl
  import wdg_seq_pkg::*;
#(
  parameter int PAW = 12,
  parameter int CW  = 32
) (
  input  logic          clk,
  input  logic          resetn,
  apbif.master          apbm,
  input  logic          cfg_req,
  input  logic [31:0]   cfg_load,
  input  logic          cfg_inten,
  input  logic          cfg_resen,
  input  logic          feed_req,
  input  logic          dis_req,
  input  logic          auto_en,
  input  logic [CW-1:0] auto_ival,
  output logic          busy,
  output logic          done,
  output logic          err
);

  wdg_state_e    state_q, state_d;
  wdg_seq_e      seq_q, seq_d;
  wdg_step_e     step_q, step_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic          pend_cfg_q, pend_cfg_d;
  logic          pend_feed_q, pend_feed_d;
  logic          pend_dis_q, pend_dis_d;
  logic [CW-1:0] auto_cnt_q, auto_cnt_d;
  logic [31:0]   load_q, load_d;
  logic [1:0]    ctrl_q, ctrl_d;

  logic          auto_tick;
  logic          accept;
  logic          wr_start;
  wdg_step_e     wr_step;
  logic [PAW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          wr_done;
  logic          wr_slverr;

  // Auto-feed timer keeps running while a sequence is in flight.
  always_comb begin
    auto_cnt_d = auto_cnt_q;
    auto_tick  = 1'b0;
    if (!auto_en) begin
      auto_cnt_d = '0;
    end else if (auto_ival != '0) begin
      if (auto_cnt_q >= auto_ival - CW'(1)) begin
        auto_cnt_d = '0;
        auto_tick  = 1'b1;
      end else begin
        auto_cnt_d = auto_cnt_q + CW'(1);
      end
    end
    if (state_q == ST_DONE && seq_q == SEQ_DIS) begin
      auto_cnt_d = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    step_d      = step_q;
    last_d      = last_q;
    err_d       = err_q;
    load_d      = load_q;
    ctrl_d      = ctrl_q;
    pend_cfg_d  = pend_cfg_q | cfg_req;
    pend_feed_d = pend_feed_q | feed_req | auto_tick;
    pend_dis_d  = pend_dis_q | dis_req;
    accept      = 1'b0;
    wr_start    = 1'b0;
    wr_step     = step_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_dis_q) begin
          accept     = 1'b1;
          seq_d      = SEQ_DIS;
          pend_dis_d = dis_req;
          ctrl_d     = 2'b00;
        end else if (pend_cfg_q) begin
          accept     = 1'b1;
          seq_d      = SEQ_CFG;
          pend_cfg_d = cfg_req;
          load_d     = cfg_load;
          ctrl_d     = {cfg_resen, cfg_inten};
        end else if (pend_feed_q) begin
          accept      = 1'b1;
          seq_d       = SEQ_FEED;
          pend_feed_d = feed_req | auto_tick;
        end
        if (accept) begin
          state_d  = ST_SETUP;
          step_d   = STP_UNLOCK;
          last_d   = 1'b0;
          wr_start = 1'b1;
          wr_step  = STP_UNLOCK;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (wr_done) begin
          if (wr_slverr) begin
            err_d = 1'b1;
          end
          // A failed write skips the rest so the watchdog is always relocked.
          if (step_q == STP_LOCK) begin
            if (wr_slverr) begin
              state_d = ST_DONE;
            end else begin
              last_d  = 1'b1;
              state_d = ST_NEXT;
            end
          end else begin
            step_d  = wr_slverr ? STP_LOCK : step_next(seq_q, step_q);
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (last_q) begin
          state_d = ST_DONE;
        end else begin
          wr_start = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_addr = PAW'(step_addr(wr_step));
  assign wr_data = step_data(wr_step, load_q, ctrl_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      seq_q       <= SEQ_FEED;
      step_q      <= STP_UNLOCK;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      pend_cfg_q  <= 1'b0;
      pend_feed_q <= 1'b0;
      pend_dis_q  <= 1'b0;
      auto_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      step_q      <= step_d;
      last_q      <= last_d;
      err_q       <= err_d;
      pend_cfg_q  <= pend_cfg_d;
      pend_feed_q <= pend_feed_d;
      pend_dis_q  <= pend_dis_d;
      auto_cnt_q  <= auto_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    load_q <= load_d;
    ctrl_q <= ctrl_d;
  end

  wdg_seq_apbwr #(.PAW(PAW)) u_wr (
    .clk     (clk),
    .resetn  (resetn),
    .start   (wr_start),
    .addr    (wr_addr),
    .data    (wr_data),
    .pready  (apbm.pready),
    .pslverr (apbm.pslverr),
    .psel    (apbm.psel),
    .penable (apbm.penable),
    .pwrite  (apbm.pwrite),
    .paddr   (apbm.paddr),
    .pwdata  (apbm.pwdata),
    .wr_done (wr_done),
    .slverr  (wr_slverr)
  );

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_wdg_seq_ctrl.sv
// Scoreboard bench for wdg_seq_ctrl: expected writes and done latencies are queued, a monitor checks them.
module tb_wdg_seq_ctrl;

  typedef struct packed {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_req, feed_req, dis_req;
  logic [31:0] cfg_load;
  logic        cfg_inten, cfg_resen;
  logic        auto_en;
  logic [31:0] auto_ival;
  logic        busy, done, err;

  apbif #(.AW(12)) apb ();

  wdg_seq_ctrl #(.PAW(12), .CW(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .apbm      (apb),
    .cfg_req   (cfg_req),
    .cfg_load  (cfg_load),
    .cfg_inten (cfg_inten),
    .cfg_resen (cfg_resen),
    .feed_req  (feed_req),
    .dis_req   (dis_req),
    .auto_en   (auto_en),
    .auto_ival (auto_ival),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_bad = 0;
  wr_t exp_wr[$];
  int  exp_lat[$];
  int  done_cnt = 0;

  // slave-model controls, written only by the stimulus process
  logic [11:0] stall_addr = 12'h0;
  int          stall_n = 0;
  logic [11:0] err_addr = 12'h0;
  logic        err_en = 1'b0;
  logic        gap_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // APB slave model: optional wait states and a one-shot error on a chosen address
  int acc_cnt = 0;
  initial apb.prdata = 32'h0;
  always @(negedge clk) begin
    apb.pready  = 1'b1;
    apb.pslverr = 1'b0;
    if (apb.psel && !apb.penable) acc_cnt = 0;
    if (apb.psel && apb.penable) begin
      if (apb.paddr == stall_addr && acc_cnt < stall_n) apb.pready = 1'b0;
      else if (err_en && apb.paddr == err_addr) apb.pslverr = 1'b1;
      acc_cnt++;
    end
  end

  // Monitor
  logic [11:0] su_a;
  logic [31:0] su_d;
  logic        busy_prev = 1'b0;
  int          seq_cyc = 0;
  int          cyc_g = 0;
  int          last_rise = 0;
  int          rise_idx = 0;
  always @(negedge clk) begin
    wr_t e;
    int  l;
    #1;
    cyc_g++;
    if (!gap_on) rise_idx = 0;
    if (!resetn) begin
      busy_prev = 1'b0;
    end else begin
      if (apb.psel && !apb.penable) begin
        su_a = apb.paddr;
        su_d = apb.pwdata;
      end
      if (apb.psel && apb.penable) begin
        chk("access_stable", {apb.pwrite, apb.paddr, apb.pwdata}, {1'b1, su_a, su_d});
        if (apb.pready) begin
          if (exp_wr.size() == 0) begin
            chk("unexpected_write", {apb.paddr, apb.pwdata}, 44'h0);
            if ({apb.paddr, apb.pwdata} == 44'h0) begin
              n_bad++;
              $display("FAIL unexpected_write: got addr 0 data 0 with nothing expected");
            end
          end else begin
            e = exp_wr.pop_front();
            chk("write_addr_data", {apb.paddr, apb.pwdata}, {e.a, e.d});
          end
        end
      end
      if (busy && !busy_prev) begin
        seq_cyc = 1;
        if (gap_on) begin
          if (rise_idx > 0) chk("auto_gap", cyc_g - last_rise, 20);
          rise_idx++;
          last_rise = cyc_g;
        end
      end else if (busy) begin
        seq_cyc++;
      end
      if (done) begin
        done_cnt++;
        if (exp_lat.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done pulse, expected none");
        end else begin
          l = exp_lat.pop_front();
          chk("done_latency", seq_cyc, l);
        end
      end
      busy_prev = busy;
    end
  end

  task automatic push_wr(input logic [11:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_wr.push_back(w);
  endtask

  task automatic push_feed(input int lat);
    push_wr(12'hC00, 32'h1ACCE551);
    push_wr(12'h00C, 32'h1);
    push_wr(12'hC00, 32'h0);
    exp_lat.push_back(lat);
  endtask

  task automatic pulse(input logic c, input logic f, input logic d);
    @(negedge clk);
    cfg_req  = c;
    feed_req = f;
    dis_req  = d;
    @(negedge clk);
    cfg_req  = 1'b0;
    feed_req = 1'b0;
    dis_req  = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_lat.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", (n < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int n;
    resetn    = 1'b0;
    cfg_req   = 1'b0;
    feed_req  = 1'b0;
    dis_req   = 1'b0;
    cfg_load  = 32'h0;
    cfg_inten = 1'b0;
    cfg_resen = 1'b0;
    auto_en   = 1'b0;
    auto_ival = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_apb", {apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata}, 47'h0);
    chk("rst_status", {busy, done, err}, 3'b000);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // cfg sequence
    cfg_load = 32'h0000_1000; cfg_inten = 1'b1; cfg_resen = 1'b1;
    push_wr(12'hC00, 32'h1ACCE551);
    push_wr(12'h000, 32'h0000_1000);
    push_wr(12'h008, 32'h3);
    push_wr(12'hC00, 32'h0);
    exp_lat.push_back(13);
    pulse(1'b1, 1'b0, 1'b0);
    drain(100);
    chk("cfg_err_clear", err, 0);

    // feed with three wait states on INTCLR
    stall_addr = 12'h00C; stall_n = 3;
    push_feed(13);
    pulse(1'b0, 1'b1, 1'b0);
    drain(100);
    stall_n = 0;

    // dis+feed together, then cfg while busy: order dis, cfg, feed
    cfg_load = 32'h0000_55AA; cfg_inten = 1'b0; cfg_resen = 1'b1;
    push_wr(12'hC00, 32'h1ACCE551);
    push_wr(12'h008, 32'h0);
    push_wr(12'hC00, 32'h0);
    exp_lat.push_back(10);
    push_wr(12'hC00, 32'h1ACCE551);
    push_wr(12'h000, 32'h0000_55AA);
    push_wr(12'h008, 32'h2);
    push_wr(12'hC00, 32'h0);
    exp_lat.push_back(13);
    push_feed(10);
    d0 = done_cnt;
    pulse(1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    pulse(1'b1, 1'b0, 1'b0);
    drain(300);
    chk("merge_done_count", done_cnt - d0, 3);

    // auto-feed every 20 cycles for 90 enabled edges -> ticks at edges 19,39,59,79
    auto_ival = 32'd20;
    for (int i = 0; i < 4; i++) push_feed(10);
    d0 = done_cnt;
    gap_on = 1'b1;
    @(negedge clk);
    auto_en = 1'b1;
    repeat (90) @(posedge clk);
    #1 auto_en = 1'b0;
    drain(200);
    gap_on = 1'b0;
    chk("auto_feed_count", done_cnt - d0, 4);

    // interval 0 inhibits auto-feed
    auto_ival = 32'd0;
    d0 = done_cnt;
    @(negedge clk);
    auto_en = 1'b1;
    repeat (100) @(negedge clk);
    auto_en = 1'b0;
    chk("auto_ival0_no_feed", done_cnt - d0, 0);
    chk("auto_ival0_idle", busy, 0);

    // pslverr on LOAD: jump to relock, sticky err
    err_addr = 12'h000; err_en = 1'b1;
    cfg_load = 32'h0000_2222; cfg_inten = 1'b1; cfg_resen = 1'b0;
    push_wr(12'hC00, 32'h1ACCE551);
    push_wr(12'h000, 32'h0000_2222);
    push_wr(12'hC00, 32'h0);
    exp_lat.push_back(10);
    pulse(1'b1, 1'b0, 1'b0);
    drain(100);
    err_en = 1'b0;
    chk("slverr_err_set", err, 1);
    push_feed(10);
    pulse(1'b0, 1'b1, 1'b0);
    drain(100);
    chk("err_sticky", err, 1);

    // async reset while a feed sits in ACCESS with a dis pending
    stall_addr = 12'hC00; stall_n = 1000;
    pulse(1'b0, 1'b1, 1'b0);
    n = 0;
    while (!(apb.psel && apb.penable) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_access", (apb.psel && apb.penable), 1);
    pulse(1'b0, 1'b0, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_drops_apb", {apb.psel, apb.penable}, 2'b00);
    chk("rst_busy_err", {busy, err}, 2'b00);
    stall_n = 0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (15) @(negedge clk);
    chk("rst_pending_cleared", busy, 0);
    push_feed(10);
    pulse(1'b0, 1'b1, 1'b0);
    drain(100);

    chk("writes_left", exp_wr.size(), 0);
    chk("dones_left", exp_lat.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
